i2c_reg_sequencer: RTL and testbench

I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

---
 rtl/i2c_reg_sequencer.sv | 179 +++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: sequences one I2C register write or register read
// through a byte-level transceiver.
//   clk, rst_n           clock, asynchronous active-low reset
//   req_en               one-cycle start pulse, accepted only while idle
//   req_write            1 = register write, 0 = register read
//   req_dev              7-bit device address
//   req_reg, req_wdata   register address, write data byte
//   busy                 transaction in flight, up to and including the done cycle
//   done, nak            end-of-transaction pulse; nak = some byte was NAKed
//   rdata                last successfully read byte
//   cin                  commands to the transceiver (one enable per cycle at most)
//   cout                 transceiver status (x_busy, tx_ack, rx_rdy, rx_out)
package i2c_reg_sequencer_pkg;
    typedef struct packed {
        logic       start_en;
        logic       restart_en;
        logic       stop_en;
        logic       tx_en;
        logic [7:0] tx_data;
        logic       rx_en;
        logic       rx_ack;
    } cin_t;

    typedef struct packed {
        logic       x_busy;
        logic       tx_ack;
        logic       rx_rdy;
        logic [7:0] rx_out;
    } cout_t;
endpackage

module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter bit NAK_ABORT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_en,
    input  logic       req_write,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic       nak,
    output logic [7:0] rdata,
    output cin_t       cin,
    input  cout_t      cout
);

    typedef enum logic [3:0] {
        IDLE, START, TXDEV, TXREG, TXDAT, RESTART, TXDEVR, RX, STOP, FIN
    } state_t;

    state_t     state, state_nx;
    logic       wait_ph, wait_nx;   // 0 = ISSUE phase, 1 = WAIT phase
    logic       accept, step_done, is_tx, abort;

    logic       wr_q, nak_q, ready_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wd_q, rx_q;

    assign is_tx = (state == TXDEV) || (state == TXREG) ||
                   (state == TXDAT) || (state == TXDEVR);
    // Only the byte just finished can trigger an abort; earlier NAKs would
    // already have diverted the sequence to STOP.
    assign abort = NAK_ABORT && is_tx && !cout.tx_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wait_ph <= 1'b0;
        end else begin
            state   <= state_nx;
            wait_ph <= wait_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wait_nx   = wait_ph;
        cin       = '0;
        done      = 1'b0;
        accept    = 1'b0;
        step_done = 1'b0;

        // tx_data is a function of the state alone, so it stays put from the
        // enable cycle through the whole WAIT phase.
        case (state)
            TXDEV:   cin.tx_data = {dev_q, 1'b0};
            TXREG:   cin.tx_data = reg_q;
            TXDAT:   cin.tx_data = wd_q;
            TXDEVR:  cin.tx_data = {dev_q, 1'b1};
            default: cin.tx_data = 8'h00;
        endcase
        // Only a single byte is ever read, so it is always NAKed (rx_ack=0).
        cin.rx_ack = 1'b0;

        case (state)
            IDLE: begin
                // ready_q blocks acceptance until the transceiver has been
                // seen idle once after reset.
                if (req_en && (ready_q || !cout.x_busy)) begin
                    accept   = 1'b1;
                    state_nx = START;
                    wait_nx  = 1'b0;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                if (!cout.x_busy) begin
                    if (!wait_ph) begin
                        wait_nx = 1'b1;
                        case (state)
                            START:   cin.start_en   = 1'b1;
                            RESTART: cin.restart_en = 1'b1;
                            RX:      cin.rx_en      = 1'b1;
                            STOP:    cin.stop_en    = 1'b1;
                            default: cin.tx_en      = 1'b1;
                        endcase
                    end else begin
                        step_done = 1'b1;
                        wait_nx   = 1'b0;
                        case (state)
                            START:   state_nx = TXDEV;
                            TXDEV:   state_nx = abort ? STOP : TXREG;
                            TXREG:   state_nx = abort ? STOP : (wr_q ? TXDAT : RESTART);
                            TXDAT:   state_nx = STOP;
                            RESTART: state_nx = TXDEVR;
                            TXDEVR:  state_nx = abort ? STOP : RX;
                            RX:      state_nx = STOP;
                            STOP:    state_nx = FIN;
                            default: state_nx = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wd_q    <= '0;
            nak_q   <= 1'b0;
            rx_q    <= '0;
            rdata   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (!cout.x_busy)
                ready_q <= 1'b1;
            if (accept) begin
                wr_q  <= req_write;
                dev_q <= req_dev;
                reg_q <= req_reg;
                wd_q  <= req_wdata;
            end
            if (step_done && is_tx && !cout.tx_ack)
                nak_q <= 1'b1;
            if (state == RX && cout.rx_rdy)
                rx_q <= cout.rx_out;
            if (state == FIN) begin
                if (!wr_q && !nak_q)
                    rdata <= rx_q;
                nak_q <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign nak  = done & nak_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: two instances (NAK_ABORT=1 and 0), each with
// a behavioural transceiver of random latency. Every transceiver command is
// logged and compared against the sequence the transaction rules predict.
module tb_i2c_reg_sequencer;
    import i2c_reg_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_en [2] = '{1'b0, 1'b0};
    logic       req_write = 1'b0;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0;
    logic [7:0] req_wdata = '0;
    logic       busy [2];
    logic       done [2];
    logic       nak [2];
    logic [7:0] rdata [2];
    cin_t       cin [2];
    cout_t      cout [2];

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.NAK_ABORT(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_en(req_en[0]), .req_write(req_write),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .busy(busy[0]), .done(done[0]), .nak(nak[0]), .rdata(rdata[0]),
        .cin(cin[0]), .cout(cout[0]));

    i2c_reg_sequencer #(.NAK_ABORT(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .req_en(req_en[1]), .req_write(req_write),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .busy(busy[1]), .done(done[1]), .nak(nak[1]), .rdata(rdata[1]),
        .cin(cin[1]), .cout(cout[1]));

    // ---------------- transceiver model ----------------
    int          nak_at = -1;      // index of the tx byte to NAK, -1 = none
    int          rx_force = -1;    // fixed rx byte, -1 = random
    logic        hold_busy = 1'b1;
    logic        spur_en = 1'b0;   // random spurious busy while idle

    int          cnt [2] = '{0, 0};
    logic        ack_r [2] = '{1'b1, 1'b1};
    logic        rdy_r [2] = '{1'b0, 1'b0};
    logic [7:0]  rx_r [2] = '{8'h00, 8'h00};
    logic        op_rx [2] = '{1'b0, 1'b0};
    logic        op_tx [2] = '{1'b0, 1'b0};
    logic [7:0]  last_tx [2] = '{8'h00, 8'h00};
    int          tx_idx [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          proto_err = 0;
    logic [7:0]  last_rx = 8'h00;
    logic [10:0] evq [$];          // {type, data}: 1 start 2 restart 3 stop 4 tx 5 rx
    cin_t        mc;
    int          nen;
    logic [7:0]  rv;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cout[i].x_busy = (cnt[i] != 0) || hold_busy;
            cout[i].tx_ack = ack_r[i];
            cout[i].rx_rdy = rdy_r[i];
            cout[i].rx_out = rx_r[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mc  = cin[i];
            nen = int'(mc.start_en) + int'(mc.restart_en) + int'(mc.stop_en) +
                  int'(mc.tx_en) + int'(mc.rx_en);
            if (done[i]) done_cnt[i]++;
            if (nen > 1 || (nen != 0 && cout[i].x_busy)) proto_err++;
            if (rst_n && busy[i] && cnt[i] != 0 && op_tx[i] && mc.tx_data != last_tx[i])
                proto_err++;
            rdy_r[i] <= (cnt[i] == 1) && op_rx[i];
            if (nen != 0) begin
                cnt[i]   <= $urandom_range(1, 3);
                op_rx[i] <= mc.rx_en;
                op_tx[i] <= mc.tx_en;
                if (mc.start_en) begin
                    evq.push_back({3'd1, 8'h00});
                    tx_idx[i] = 0;
                end
                if (mc.restart_en) evq.push_back({3'd2, 8'h00});
                if (mc.stop_en)    evq.push_back({3'd3, 8'h00});
                if (mc.tx_en) begin
                    evq.push_back({3'd4, mc.tx_data});
                    ack_r[i]   <= (tx_idx[i] != nak_at);
                    last_tx[i] <= mc.tx_data;
                    tx_idx[i]++;
                end
                if (mc.rx_en) begin
                    evq.push_back({3'd5, 7'd0, mc.rx_ack});
                    rv = (rx_force >= 0) ? rx_force[7:0] : 8'($urandom);
                    rx_r[i] <= rv;
                    last_rx = rv;
                end
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
            end else if (spur_en && $urandom_range(0, 4) == 0) begin
                cnt[i]   <= 1;
                op_rx[i] <= 1'b0;
                op_tx[i] <= 1'b0;
            end
        end
    end

    // ---------------- reference model and checking ----------------
    int          total = 0;
    int          bad = 0;
    logic [10:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected command sequence straight from the transaction rules.
    function automatic logic build_exp(input logic wr, input logic [6:0] dev,
                                       input logic [7:0] rg, input logic [7:0] wd,
                                       input int nk, input logic abort_on_nak);
        logic [10:0] items [$];
        logic        nk_seen = 1'b0;
        int          txi = 0;
        expq.delete();
        items.push_back({3'd4, dev, 1'b0});
        items.push_back({3'd4, rg});
        if (wr) begin
            items.push_back({3'd4, wd});
        end else begin
            items.push_back({3'd2, 8'h00});
            items.push_back({3'd4, dev, 1'b1});
            items.push_back({3'd5, 8'h00});
        end
        expq.push_back({3'd1, 8'h00});
        foreach (items[k]) begin
            expq.push_back(items[k]);
            if (items[k][10:8] == 3'd4) begin
                if (txi == nk) nk_seen = 1'b1;
                txi++;
                if (nk_seen && abort_on_nak) break;
            end
        end
        expq.push_back({3'd3, 8'h00});
        return nk_seen;
    endfunction

    task automatic run_txn(input int inst, input logic wr, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd, input int nk,
                           input logic mid_pulse, input logic fin_pulse);
        int         base = evq.size();
        int         d0 = done_cnt[inst];
        logic [7:0] prev = rdata[inst];
        logic       exp_nak;
        int         cyc = 0;
        nak_at    = nk;
        req_write = wr;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        req_en[inst] = 1'b1;
        @(negedge clk);
        req_en[inst] = 1'b0;
        chk("busy_after_req", busy[inst], 1);
        while (!done[inst] && cyc < 300) begin
            if (mid_pulse && cyc == 3) begin
                req_en[inst] = 1'b1;
                req_write = ~wr;
                req_dev   = ~dev;
                req_wdata = ~wd;
            end else begin
                req_en[inst] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_en[inst] = 1'b0;
        chk("done_timeout", cyc < 300, 1);
        exp_nak = build_exp(wr, dev, rg, wd, nk, inst == 0);
        chk("nak_at_done", nak[inst], exp_nak);
        chk("busy_at_done", busy[inst], 1);
        if (fin_pulse) req_en[inst] = 1'b1;
        @(negedge clk);
        req_en[inst] = 1'b0;
        chk("rdata", rdata[inst], (!wr && !exp_nak) ? last_rx : prev);
        repeat (4) @(negedge clk);
        chk("busy_after", busy[inst], 0);
        chk("done_count", done_cnt[inst] - d0, 1);
        chk("event_count", evq.size() - base, expq.size());
        foreach (expq[k]) chk($sformatf("event%0d", k), evq[base + k], expq[k]);
        chk("protocol", proto_err, 0);
    endtask

    initial begin
        int base;
        int d0;
        int cyc;
        int r;
        int nk;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_nak", nak[i], 0);
            chk("rst_rdata", rdata[i], 0);
            chk("rst_cin", cin[i], 0);
        end

        // No acceptance while the transceiver is still busy after reset
        rst_n = 1'b1;
        @(negedge clk);
        req_en[0] = 1'b1;
        @(negedge clk);
        req_en[0] = 1'b0;
        chk("no_accept_xbusy", busy[0], 0);
        hold_busy = 1'b0;
        @(negedge clk);

        // Directed write, read, NAK cases
        run_txn(0, 1'b1, 7'h50, 8'h10, 8'hA5, -1, 1'b0, 1'b0);
        rx_force = 8'h3C;
        run_txn(0, 1'b0, 7'h50, 8'h22, 8'h00, -1, 1'b0, 1'b0);
        chk("read_3c", rdata[0], 8'h3C);
        rx_force = -1;
        run_txn(0, 1'b1, 7'h50, 8'h10, 8'hA5, 0, 1'b0, 1'b0);
        run_txn(1, 1'b1, 7'h50, 8'h10, 8'hA5, 0, 1'b0, 1'b0);
        run_txn(1, 1'b0, 7'h50, 8'h22, 8'h00, 2, 1'b0, 1'b0);

        // req_en mid-transaction and in the FIN cycle
        run_txn(0, 1'b1, 7'h2A, 8'h33, 8'h5C, -1, 1'b1, 1'b1);

        // Reset during TXREG WAIT
        base = evq.size();
        d0 = done_cnt[0];
        nak_at = -1;
        req_write = 1'b1;
        req_dev = 7'h50;
        req_reg = 8'h10;
        req_wdata = 8'hA5;
        req_en[0] = 1'b1;
        @(negedge clk);
        req_en[0] = 1'b0;
        cyc = 0;
        while (evq.size() < base + 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_txreg", cyc < 200, 1);
        chk("in_wait_xbusy", cout[0].x_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy[0], 0);
        chk("midrst_done", done[0], 0);
        chk("midrst_rdata", rdata[0], 0);
        chk("midrst_cin", cin[0], 0);
        repeat (4) @(negedge clk);
        chk("midrst_no_done", done_cnt[0] - d0, 0);
        chk("midrst_no_stop", evq.size() - base, 3);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(0, 1'b1, 7'h50, 8'h10, 8'hA5, -1, 1'b0, 1'b0);

        // Randomized transactions with spurious transceiver busy
        spur_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 4);
            nk = (r < 2) ? -1 : r - 2;
            run_txn($urandom_range(0, 1), 1'($urandom), 7'($urandom), 8'($urandom),
                    8'($urandom), nk, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
